// File: rtl/fir_pkg.sv
// Shared constants, sample/accumulator types, coefficients and the saturation
// helper for the FIR stage and any golden model that must agree with it.
package fir_pkg;

  localparam int TAPS   = 4;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 36;
  localparam int SHIFT  = 0;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef struct packed {
    sample_t data;
    logic    sat;
  } sat_result_t;

  localparam coef_t COEF [TAPS] = '{16'sd2, 16'sd3, -16'sd2, 16'sd8};

  // Clip the scaled accumulator into the sample range; never wraps.
  function automatic sat_result_t sat_to_sample(input acc_t acc);
    acc_t        sh;
    acc_t        max_v;
    acc_t        min_v;
    sat_result_t res;
    sh    = acc >>> SHIFT;
    max_v = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    min_v = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (sh > max_v) begin
      res.data = {1'b0, {(DATA_W-1){1'b1}}};
      res.sat  = 1'b1;
    end else if (sh < min_v) begin
      res.data = {1'b1, {(DATA_W-1){1'b0}}};
      res.sat  = 1'b1;
    end else begin
      res.data = sh[DATA_W-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_filter_stage_mac.sv
// Combinational TAPS-wide multiply-accumulate over the delay line, computed
// at full accumulator width so no intermediate sum can overflow.
module fir_mac
  import fir_pkg::*;
(
  input  sample_t i_taps [TAPS],
  output acc_t    o_acc
);

  always_comb begin
    o_acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      o_acc = o_acc + acc_t'(i_taps[k]) * acc_t'(COEF[k]);
    end
  end

endmodule

// File: rtl/fir_filter_stage.sv
// Two-stage FIR: valid-gated delay line, then registered saturating MAC result.
// All state lives here; fir_mac is purely combinational.
module fir_filter_stage
  import fir_pkg::*;
(
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat
);

  sample_t     r_taps [TAPS];
  logic        r_v1;
  logic        r_out_valid;
  sample_t     r_out_data;
  logic        r_out_sat;
  acc_t        w_acc;
  sat_result_t w_sat;

  fir_mac u_mac (
    .i_taps (r_taps),
    .o_acc  (w_acc)
  );

  assign w_sat = sat_to_sample(w_acc);

  // Delay line only shifts on valid samples, so gaps never smear history.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
      r_v1 <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < TAPS; k++) r_taps[k] <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_taps[0] <= in_data;
        for (int k = 1; k < TAPS; k++) r_taps[k] <= r_taps[k-1];
      end
    end
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      r_out_data  <= w_sat.data;
      r_out_sat   <= w_sat.sat & r_v1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_fir_filter_stage.sv
// Directed bench for fir_filter_stage: impulse, step, saturation, gaps, clear
// and asynchronous reset, with hand-computed expected outputs.
module tb_fir_filter_stage;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               clear;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_sat;

  int total_cnt = 0;
  int pass_cnt  = 0;

  fir_filter_stage dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .clear          (clear),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sat        (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input bit v, input int d, input bit c);
    in_valid = v;
    in_data  = d[15:0];
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input bit ev, input int ed, input bit es);
    chk({tag, ".valid"}, int'(out_valid), int'(ev));
    chk({tag, ".data"},  int'(out_data),  ed);
    chk({tag, ".sat"},   int'(out_sat),   int'(es));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;

    // Impulse: out_valid rises two edges after the first accepted sample
    step(1, 1, 0); chk_out("imp0", 0, 0, 0);
    step(1, 0, 0); chk_out("imp1", 1, 2, 0);
    step(1, 0, 0); chk_out("imp2", 1, 3, 0);
    step(1, 0, 0); chk_out("imp3", 1, -2, 0);
    step(1, 0, 0); chk_out("imp4", 1, 8, 0);
    step(0, 0, 0); chk_out("imp5", 1, 0, 0);
    step(0, 0, 0); chk_out("imp6", 0, 0, 0);

    // Step of 100
    step(0, 0, 1); chk_out("clr_a", 0, 0, 0);
    step(1, 100, 0); chk_out("stp0", 0, 0, 0);
    step(1, 100, 0); chk_out("stp1", 1, 200, 0);
    step(1, 100, 0); chk_out("stp2", 1, 500, 0);
    step(1, 100, 0); chk_out("stp3", 1, 300, 0);
    step(1, 100, 0); chk_out("stp4", 1, 1100, 0);
    step(0, 0, 0);   chk_out("stp5", 1, 1100, 0);

    // Positive saturation: even 2*32767 already exceeds the range
    step(0, 0, 1); chk_out("clr_b", 0, 0, 0);
    step(1, 32767, 0); chk_out("psat0", 0, 0, 0);
    step(1, 32767, 0); chk_out("psat1", 1, 32767, 1);
    step(1, 32767, 0); chk_out("psat2", 1, 32767, 1);
    step(1, 32767, 0); chk_out("psat3", 1, 32767, 1);
    step(0, 0, 0);     chk_out("psat4", 1, 32767, 1);
    step(0, 0, 0);     chk_out("psat5", 0, 32767, 0);

    // Negative saturation
    step(0, 0, 1); chk_out("clr_c", 0, 0, 0);
    step(1, -32768, 0); chk_out("nsat0", 0, 0, 0);
    step(1, -32768, 0); chk_out("nsat1", 1, -32768, 1);
    step(1, -32768, 0); chk_out("nsat2", 1, -32768, 1);
    step(1, -32768, 0); chk_out("nsat3", 1, -32768, 1);
    step(0, 0, 0);      chk_out("nsat4", 1, -32768, 1);

    // Exactly -32768 is representable and must not flag saturation
    step(0, 0, 1); chk_out("clr_d", 0, 0, 0);
    step(1, -16384, 0); chk_out("edge0", 0, 0, 0);
    step(1, 0, 0);      chk_out("edge1", 1, -32768, 0);
    step(0, 0, 0);      chk_out("edge2", 1, -32768, 1);

    // Valid gaps: pattern 1,0,0,1,0,1,1
    step(0, 0, 1); chk_out("clr_e", 0, 0, 0);
    step(1, 1, 0); chk_out("gap0", 0, 0, 0);
    step(0, 0, 0); chk_out("gap1", 1, 2, 0);
    step(0, 0, 0); chk_out("gap2", 0, 2, 0);
    step(1, 0, 0); chk_out("gap3", 0, 2, 0);
    step(0, 0, 0); chk_out("gap4", 1, 3, 0);
    step(1, 0, 0); chk_out("gap5", 0, 3, 0);
    step(1, 0, 0); chk_out("gap6", 1, -2, 0);
    step(0, 0, 0); chk_out("gap7", 1, 8, 0);
    step(0, 0, 0); chk_out("gap8", 0, 8, 0);

    // Clear wins over a simultaneous valid sample
    step(0, 0, 1);   chk_out("clr_f", 0, 0, 0);
    step(1, 100, 0); chk_out("cl0", 0, 0, 0);
    step(1, 100, 0); chk_out("cl1", 1, 200, 0);
    step(1, 100, 0); chk_out("cl2", 1, 500, 0);
    step(1, 100, 1); chk_out("cl3", 0, 0, 0);
    step(1, 1, 0);   chk_out("cl4", 0, 0, 0);
    step(1, 0, 0);   chk_out("cl5", 1, 2, 0);
    step(1, 0, 0);   chk_out("cl6", 1, 3, 0);
    step(1, 0, 0);   chk_out("cl7", 1, -2, 0);
    step(0, 0, 0);   chk_out("cl8", 1, 8, 0);

    // Asynchronous reset mid-stream, outputs drop without a clock edge
    step(1, 100, 0);
    step(1, 100, 0); chk_out("ar0", 1, 200, 0);
    #2 rst = 1'b1;
    #1 chk_out("ar_async", 0, 0, 0);
    @(posedge clk); #1;
    chk_out("ar_hold", 0, 0, 0);
    rst = 1'b0;
    step(1, 1, 0); chk_out("ar1", 0, 0, 0);
    step(1, 0, 0); chk_out("ar2", 1, 2, 0);
    step(1, 0, 0); chk_out("ar3", 1, 3, 0);
    step(1, 0, 0); chk_out("ar4", 1, -2, 0);
    step(0, 0, 0); chk_out("ar5", 1, 8, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
